// File: rtl/hazard_detection_unit.sv
// Hazard detection for a 5-stage pipeline: load-use and branch-operand stalls, taken-branch flush, multi-cycle mul/div hold.
// Latency: all control outputs are combinational from the current FSM state and inputs, so a stall takes effect in the cycle it is detected.
// Backpressure: Hold freezes PC/IF/ID/EX and bubbles EX/MEM; a data stall freezes PC/IF/ID and bubbles ID/EX; a flush only clears IF/ID.
//
// Ports:
//   clk, reset                  pipeline clock, asynchronous active-high reset
//   ID_*                        source registers / usage / branch info of the ID instruction
//   EX_*, MEM_*                 load / write-back info of the EX and MEM instructions
//   EX_MulDivStart              EX instruction is a multiply/divide
//   PCWrite, IF_ID_Write, ID_EX_Write        stage enables (1 = advance)
//   IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble clear the control fields of that pipeline register
//   MulDivBusy                  FSM is in MD_BUSY
//   StallCycles                 saturating count of cycles with PCWrite = 0
module hazard_detection_unit #(
    parameter int MULDIV_LAT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_UsesRs,
    input  logic        ID_UsesRt,
    input  logic        ID_Branch,
    input  logic        BranchTaken,
    input  logic        EX_MemRead,
    input  logic        EX_RegWrite,
    input  logic [4:0]  EX_WriteRegister,
    input  logic        MEM_MemRead,
    input  logic [4:0]  MEM_WriteRegister,
    input  logic        EX_MulDivStart,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        ID_EX_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Bubble,
    output logic        EX_MEM_Bubble,
    output logic        MulDivBusy,
    output logic [15:0] StallCycles
);

    typedef enum logic [1:0] {RUN, MD_BUSY, MD_DONE} state_t;

    localparam logic       LAT_GT1  = (MULDIV_LAT > 1);
    localparam logic       LAT_GT2  = (MULDIV_LAT > 2);
    // Cycles remaining in MD_BUSY after the first (RUN) hold cycle.
    localparam logic [5:0] CNT_INIT = 6'((MULDIV_LAT > 2) ? (MULDIV_LAT - 2) : 0);

    state_t     state;
    logic [5:0] cnt;

    logic ex_match;
    logic mem_match;
    logic load_use;
    logic branch_dep;
    logic hold;

    // Register $0 is hardwired to zero, so writing it never creates a dependency.
    assign ex_match  = (EX_WriteRegister != 5'd0) &&
                       ((ID_UsesRs && (EX_WriteRegister == ID_rs)) ||
                        (ID_UsesRt && (EX_WriteRegister == ID_rt)));
    assign mem_match = (MEM_WriteRegister != 5'd0) &&
                       ((ID_UsesRs && (MEM_WriteRegister == ID_rs)) ||
                        (ID_UsesRt && (MEM_WriteRegister == ID_rt)));

    assign load_use   = EX_MemRead && ex_match;
    // Branches compare in ID, so they need the operand before forwarding from EX/MEM is possible.
    assign branch_dep = ID_Branch && ((EX_RegWrite && ex_match) || (MEM_MemRead && mem_match));

    // The start request is only honoured in RUN; the held instruction keeps it asserted.
    assign hold = ((state == RUN) && EX_MulDivStart && LAT_GT1) || (state == MD_BUSY);

    assign MulDivBusy = (state == MD_BUSY);

    always_comb begin
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Bubble  = 1'b0;
        EX_MEM_Bubble = 1'b0;
        if (hold) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
        end else if (load_use || branch_dep) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else if (ID_Branch && BranchTaken) begin
            IF_ID_Flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 6'd0;
        end else begin
            case (state)
                RUN: begin
                    if (hold) begin
                        if (LAT_GT2) begin
                            state <= MD_BUSY;
                            cnt   <= CNT_INIT;
                        end else begin
                            state <= MD_DONE;
                        end
                    end
                end
                MD_BUSY: begin
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        state <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    // One free cycle lets the finished instruction leave EX without retriggering.
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCycles <= 16'd0;
        end else if (!PCWrite && (StallCycles != 16'hFFFF)) begin
            StallCycles <= StallCycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed-vector bench for hazard_detection_unit (MULDIV_LAT = 4).
// Stimulus pushes the hand-computed expected outputs into a queue; a monitor on the falling edge pops and compares.
module tb_hazard_detection_unit;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       br;
        logic       bt;
        logic       exmr;
        logic       exrw;
        logic [4:0] exwr;
        logic       memr;
        logic [4:0] memwr;
        logic       md;
    } in_t;

    // ctl bit order: PCWrite, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble, MulDivBusy
    typedef struct packed {
        logic [6:0]  ctl;
        logic [15:0] sc;
    } exp_t;

    localparam logic [6:0] C_RUN   = 7'b1110000;
    localparam logic [6:0] C_STALL = 7'b0010100;
    localparam logic [6:0] C_FLUSH = 7'b1111000;
    localparam logic [6:0] C_HOLD0 = 7'b0000010;
    localparam logic [6:0] C_HOLDB = 7'b0000011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  ID_rs = '0, ID_rt = '0;
    logic        ID_UsesRs = 1'b0, ID_UsesRt = 1'b0, ID_Branch = 1'b0, BranchTaken = 1'b0;
    logic        EX_MemRead = 1'b0, EX_RegWrite = 1'b0;
    logic [4:0]  EX_WriteRegister = '0;
    logic        MEM_MemRead = 1'b0;
    logic [4:0]  MEM_WriteRegister = '0;
    logic        EX_MulDivStart = 1'b0;
    logic        PCWrite, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble, MulDivBusy;
    logic [15:0] StallCycles;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    hazard_detection_unit #(.MULDIV_LAT(4)) dut (
        .clk(clk), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_Branch(ID_Branch), .BranchTaken(BranchTaken),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteRegister(EX_WriteRegister),
        .MEM_MemRead(MEM_MemRead), .MEM_WriteRegister(MEM_WriteRegister),
        .EX_MulDivStart(EX_MulDivStart),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble), .EX_MEM_Bubble(EX_MEM_Bubble),
        .MulDivBusy(MulDivBusy), .StallCycles(StallCycles)
    );

    // Monitor: the DUT presents a new output set every cycle; compare whatever the stimulus queued.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            logic [6:0] act;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {PCWrite, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble, MulDivBusy};
            n_tests++;
            if (act !== e.ctl || StallCycles !== e.sc) begin
                n_fail++;
                $display("FAIL %s: ctl=%b StallCycles=%0d, required ctl=%b StallCycles=%0d",
                         nm, act, StallCycles, e.ctl, e.sc);
            end
        end
    end

    task automatic step(input string nm, input in_t v, input logic rst_v,
                        input logic chk, input logic [6:0] ctl, input logic [15:0] sc);
        exp_t e;
        @(posedge clk);
        #1;
        reset             = rst_v;
        ID_rs             = v.rs;
        ID_rt             = v.rt;
        ID_UsesRs         = v.urs;
        ID_UsesRt         = v.urt;
        ID_Branch         = v.br;
        BranchTaken       = v.bt;
        EX_MemRead        = v.exmr;
        EX_RegWrite       = v.exrw;
        EX_WriteRegister  = v.exwr;
        MEM_MemRead       = v.memr;
        MEM_WriteRegister = v.memwr;
        EX_MulDivStart    = v.md;
        if (chk) begin
            e.ctl = ctl;
            e.sc  = sc;
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
    endtask

    in_t idle;
    in_t v;

    initial begin
        idle = '0;

        // Reset asserted, all inputs zero.
        step("reset_state", idle, 1'b1, 1'b1, C_RUN, 16'd0);
        step("after_reset", idle, 1'b0, 1'b1, C_RUN, 16'd0);

        // Load-use on rs = $8.
        v = '0; v.exmr = 1'b1; v.exwr = 5'd8; v.rs = 5'd8; v.urs = 1'b1;
        step("load_use", v, 1'b0, 1'b1, C_STALL, 16'd0);
        step("load_use_next", idle, 1'b0, 1'b1, C_RUN, 16'd1);

        // Same pattern on $0: no dependency.
        v = '0; v.exmr = 1'b1; v.exwr = 5'd0; v.rs = 5'd0; v.urs = 1'b1;
        step("reg0_exempt", v, 1'b0, 1'b1, C_RUN, 16'd1);
        step("reg0_next", idle, 1'b0, 1'b1, C_RUN, 16'd1);

        // Register matches but rs is not actually read.
        v = '0; v.exmr = 1'b1; v.exwr = 5'd8; v.rs = 5'd8; v.urs = 1'b0;
        step("rs_unused", v, 1'b0, 1'b1, C_RUN, 16'd1);

        // lw $9 ; beq $9,... : EX cycle (LoadUse), MEM cycle (BranchDep), then taken flush.
        v = '0; v.exmr = 1'b1; v.exrw = 1'b1; v.exwr = 5'd9; v.rs = 5'd9; v.urs = 1'b1; v.br = 1'b1;
        step("ldbr_ex", v, 1'b0, 1'b1, C_STALL, 16'd1);
        v = '0; v.memr = 1'b1; v.memwr = 5'd9; v.rs = 5'd9; v.urs = 1'b1; v.br = 1'b1;
        step("ldbr_mem", v, 1'b0, 1'b1, C_STALL, 16'd2);
        v = '0; v.rs = 5'd9; v.urs = 1'b1; v.br = 1'b1; v.bt = 1'b1;
        step("ldbr_flush", v, 1'b0, 1'b1, C_FLUSH, 16'd3);
        step("ldbr_after", idle, 1'b0, 1'b1, C_RUN, 16'd3);

        // ALU write to rt feeding a taken branch: stall wins over flush.
        v = '0; v.exrw = 1'b1; v.exwr = 5'd5; v.rt = 5'd5; v.urt = 1'b1; v.br = 1'b1; v.bt = 1'b1;
        step("alu_branch_rt", v, 1'b0, 1'b1, C_STALL, 16'd3);
        step("alu_branch_next", idle, 1'b0, 1'b1, C_RUN, 16'd4);

        // Mul/div, MULDIV_LAT = 4; first cycle also carries a load-use that Hold overrides.
        v = '0; v.md = 1'b1; v.exmr = 1'b1; v.exwr = 5'd8; v.rs = 5'd8; v.urs = 1'b1;
        step("md_hold1", v, 1'b0, 1'b1, C_HOLD0, 16'd4);
        v = '0; v.md = 1'b1;
        step("md_hold2", v, 1'b0, 1'b1, C_HOLDB, 16'd5);
        step("md_hold3", v, 1'b0, 1'b1, C_HOLDB, 16'd6);
        step("md_done_noretrig", v, 1'b0, 1'b1, C_RUN, 16'd7);
        step("md_back_run", idle, 1'b0, 1'b1, C_RUN, 16'd7);

        // Reset in the middle of MD_BUSY.
        step("md2_hold1", v, 1'b0, 1'b1, C_HOLD0, 16'd7);
        step("md2_busy", v, 1'b0, 1'b1, C_HOLDB, 16'd8);
        step("reset_mid_busy", idle, 1'b1, 1'b1, C_RUN, 16'd0);
        step("post_reset", idle, 1'b0, 1'b1, C_RUN, 16'd0);

        // Saturation: 65540 consecutive load-use stalls starting from 0.
        v = '0; v.exmr = 1'b1; v.exwr = 5'd8; v.rs = 5'd8; v.urs = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            if (i == 65534 || i == 65535 || i == 65539) begin
                step("saturation", v, 1'b0, 1'b1, C_STALL, (i >= 65535) ? 16'hFFFF : 16'(i));
            end else begin
                step("saturation", v, 1'b0, 1'b0, C_STALL, 16'd0);
            end
        end
        step("saturated_idle", idle, 1'b0, 1'b1, C_RUN, 16'hFFFF);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d checks left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 SHALL have parameter MULDIV_LAT, default 32, meaning EX-stage occupancy in cycles of a multiply/divide instruction (legal range 1..64).
REQ-002 SHALL have port clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports ID_rs, ID_rt  input  5 each  source register numbers of the instruction in ID.
REQ-005 SHALL have ports ID_UsesRs, ID_UsesRt  input  1 each  ID instruction actually reads rs / rt.
REQ-006 SHALL have port ID_Branch  input  1  ID instruction is a branch, compared in ID.
REQ-007 SHALL have port BranchTaken  input  1  ID branch comparison result.
REQ-008 SHALL have ports EX_MemRead, EX_RegWrite  input  1 each  EX instruction is a load / writes a register.
REQ-009 SHALL have port EX_WriteRegister  input  5  destination register of the EX instruction.
REQ-010 SHALL have port MEM_MemRead  input  1  MEM instruction is a load.
REQ-011 SHALL have port MEM_WriteRegister  input  5  destination register of the MEM instruction.
REQ-012 SHALL have port EX_MulDivStart  input  1  EX instruction is multiply/divide.
REQ-013 SHALL have ports PCWrite, IF_ID_Write, ID_EX_Write  output  1 each  stage-register enables, 1 = advance.
REQ-014 SHALL have ports IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble  output  1 each  zero control fields of the named pipeline register.
REQ-015 SHALL have port MulDivBusy  output  1  FSM is in MD_BUSY.
REQ-016 SHALL have port StallCycles  output  16  saturating count of cycles with PCWrite = 0.

Function
REQ-017 SHALL define match(R) = (R != 0) and ((ID_UsesRs and R == ID_rs) or (ID_UsesRt and R == ID_rt)).
REQ-018 SHALL raise LoadUse = EX_MemRead and match(EX_WriteRegister).
REQ-019 SHALL raise BranchDep = ID_Branch and ((EX_RegWrite and match(EX_WriteRegister)) or (MEM_MemRead and match(MEM_WriteRegister))).
REQ-020 SHALL implement FSM states RUN, MD_BUSY, MD_DONE and a 6-bit down-counter cnt.
REQ-021 SHALL raise Hold = (state == RUN and EX_MulDivStart and MULDIV_LAT > 1) or state == MD_BUSY.
REQ-022 SHALL transition from RUN on Hold: to MD_BUSY with cnt = MULDIV_LAT-2 if MULDIV_LAT > 2, else to MD_DONE.
REQ-023 SHALL decrement cnt each cycle in MD_BUSY and move to MD_DONE in the cycle cnt == 1.
REQ-024 SHALL leave MD_DONE for RUN after exactly one cycle; EX_MulDivStart SHALL be ignored in MD_BUSY and MD_DONE, preventing retrigger by the held instruction.
REQ-025 SHALL drive, when Hold: PCWrite = IF_ID_Write = ID_EX_Write = 0, EX_MEM_Bubble = 1, ID_EX_Bubble = 0, IF_ID_Flush = 0 (total hold = MULDIV_LAT-1 cycles).
REQ-026 SHALL drive, when not Hold and (LoadUse or BranchDep): PCWrite = IF_ID_Write = 0, ID_EX_Write = 1, ID_EX_Bubble = 1, IF_ID_Flush = 0.
REQ-027 SHALL drive, when no stall and ID_Branch and BranchTaken: IF_ID_Flush = 1, all enables 1.
REQ-028 SHALL otherwise drive all enables 1 and all bubble/flush outputs 0; priority Hold > data stall > flush.
REQ-029 SHALL compute all control outputs combinationally from current state and inputs (stall in same cycle as detection).
REQ-030 SHALL increment StallCycles on each rising edge where PCWrite == 0, holding at 16'hFFFF.
REQ-031 SHALL yield a two-cycle stall for load-then-dependent-branch (EX cycle via LoadUse, MEM cycle via BranchDep).

Reset
REQ-032 SHALL on reset assertion immediately set state = RUN, cnt = 0, StallCycles = 0, independent of clk, including mid MD_BUSY.
REQ-033 SHALL, with reset asserted and all inputs 0, present PCWrite = IF_ID_Write = ID_EX_Write = 1, all bubble/flush = 0, MulDivBusy = 0.

Verification
REQ-034 SHALL verify load-use: EX_MemRead=1, EX_WriteRegister=8, ID_rs=8, ID_UsesRs=1 -> PCWrite=0, ID_EX_Bubble=1 one cycle, StallCycles 0->1.
REQ-035 SHALL verify $0 exemption: same as REQ-034 with register 0 -> no stall, StallCycles unchanged.
REQ-036 SHALL verify load-then-branch: lw $9 then beq on $9 -> two consecutive stall cycles, then BranchTaken=1 -> IF_ID_Flush=1 one cycle.
REQ-037 SHALL verify MULDIV_LAT=4, EX_MulDivStart held high -> Hold for 3 cycles, MulDivBusy high 2 cycles, one MD_DONE cycle with no hold, no retrigger.
REQ-038 SHALL verify reset asserted during MD_BUSY -> state RUN, StallCycles=0 immediately, PCWrite=1 before next clk edge.
REQ-039 SHALL verify saturation: force 65 540 stall cycles -> StallCycles stays 16'hFFFF.
